mips_main_fsm: RTL and testbench
================================

# mips_main_fsm

Main control state machine for the multicycle MIPS32 datapath. It decodes `opcode`, sequences each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and muxes. It produces the 2-bit `alu_op` consumed by the ALU decoder, which turns it into the 3-bit ALU control. It also waits on a single-bit memory ready handshake for the shared instruction/data memory.

## Interface

Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_en  out  1  PC register enable; `pc_write | (branch & zero)`; with the BNE feature, also `| (branch_ne & ~zero)`
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  destination select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = Data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct
- pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  high in DECODE when the opcode is unsupported
- state  out  4  current state, for debug

## Operation

State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable; if entered, next state is FETCH and all outputs are 0.

Outputs are Moore (a function of state only), with two exceptions: `pc_en` uses `zero`, and FETCH's `ir_write`/`pc_write` are gated by `mem_ready`. Any output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH
  - Outputs: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write = pc_write = mem_ready.
  - Next: DECODE if mem_ready, else FETCH.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next, by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - any other opcode → FETCH, with illegal_op=1
- MEMADR
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD
  - Outputs: iord=1.
  - Next: MEMWB if mem_ready, else MEMRD.
- MEMWB
  - Outputs: reg_dst=0, mem_to_reg=1, reg_write=1.
  - Next: FETCH.
- MEMWR
  - Outputs: iord=1, mem_write=1; mem_write stays high until mem_ready.
  - Next: FETCH if mem_ready, else MEMWR.
- EXEC
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next: ALUWB.
- ALUWB
  - Outputs: reg_dst=1, mem_to_reg=0, reg_write=1.
  - Next: FETCH.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; internal branch=1.
  - Next: FETCH.
- ADDIEX
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: ADDIWB.
- ADDIWB
  - Outputs: reg_dst=0, mem_to_reg=0, reg_write=1.
  - Next: FETCH.
- JUMP
  - Outputs: pc_src=10, pc_write=1.
  - Next: FETCH.

## Timing

- Reset: asserting reset sets state to FETCH immediately, without waiting for a clock edge, including mid-instruction.
  - While reset is high, outputs are the FETCH values with ir_write, pc_write and pc_en forced to 0.
  - Every other output that is 0 in FETCH is 0.
  - The first fetch begins on the first rising edge after reset deasserts.
- Cycle counts with mem_ready constantly high:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- `opcode` is sampled only in DECODE and MEMADR; the IR is stable in those states.
- `zero` is used only in BRANCH, combinationally, in the same cycle.

## Configuration

- `MIPS_FSM_BNE_EN` defined:
  - In DECODE, opcode 000101 (bne) → BRANCH.
  - An internal branch_ne flag is registered in DECODE (1 for bne, 0 for beq).
  - In BRANCH, pc_en = `branch_ne ? ~zero : zero`.
- `MIPS_FSM_BNE_EN` undefined:
  - Opcode 000101 is illegal: DECODE → FETCH with illegal_op=1.
  - No branch_ne register exists.

## Test plan

- Reset mid-EXEC, then release → state=0 immediately while reset is high, ir_write=0 and pc_en=0 during reset; with mem_ready=1, ir_write=1 and pc_en=1 on the first cycle after release.
- lw (100011), mem_ready=1 → state sequence 0,1,2,3,4; reg_write=1 and mem_to_reg=1 only in state 4; alu_op=00 throughout.
- R-type (000000) → state sequence 0,1,6,7; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
- sw (101011) with mem_ready low for 3 cycles in MEMWR → mem_write=1 for 4 consecutive cycles, then state=0; reg_write never asserts.
- beq with zero=1, then beq with zero=0 → pc_en=1 vs 0 in state 8, pc_src=01, alu_op=01; j → pc_en=1 and pc_src=10 in state 11.
- Opcode 111111 → illegal_op=1 in DECODE, next state 0. Opcode 000101 → takes the branch path only when `MIPS_FSM_BNE_EN` is defined, with pc_en=1 when zero=0.

Source files
------------

// File: rtl/mips_main_fsm.sv
// Main control FSM for the multicycle MIPS32 datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux. Define MIPS_FSM_BNE_EN to add bne support on the branch path.
module mips_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   illegal;

    // Moore control word for a state; unlisted fields and unused codes stay 0.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch     = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_FSM_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

`ifdef MIPS_FSM_BNE_EN
    logic branch_ne_q;
`endif

    // Control word is registered from the next state so it always lines up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= state_ctrl(FETCH);
`ifdef MIPS_FSM_BNE_EN
            branch_ne_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
`ifdef MIPS_FSM_BNE_EN
            if (state_q == DECODE) branch_ne_q <= (opcode == OP_BNE);
`endif
        end
    end

    logic branch_taken;
`ifdef MIPS_FSM_BNE_EN
    assign branch_taken = ctrl_q.branch & (branch_ne_q ? ~zero : zero);
`else
    assign branch_taken = ctrl_q.branch & zero;
`endif

    // FETCH write strobes wait on memory and are held off while reset is asserted.
    assign ir_write   = ctrl_q.fetch & mem_ready & ~reset;
    assign pc_en      = ctrl_q.pc_write | ir_write | branch_taken;
    assign iord       = ctrl_q.iord;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign illegal_op = illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_main_fsm.sv
// Self-checking bench for mips_main_fsm: directed instructions from the test plan, then random
// instruction streams with random memory stalls, checked cycle by cycle against an instruction-level model.
module tb_mips_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

`ifdef MIPS_FSM_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    mips_main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: state to be in, inputs that matter there, and decode facts.
    typedef struct {
        int         st;
        bit         mr;
        bit         z;
        logic [5:0] opc;
        bit         ill;
        bit         bne;
    } step_t;

    step_t q[$];

    function automatic step_t mk(int st, bit mr, bit z, logic [5:0] opc, bit ill, bit bne);
        step_t s;
        s.st = st; s.mr = mr; s.z = z; s.opc = opc; s.ill = ill; s.bne = bne;
        return s;
    endfunction

    function automatic bit is_legal(logic [5:0] opc);
        return (opc == 6'b100011) || (opc == 6'b101011) || (opc == 6'b000000) ||
               (opc == 6'b000100) || (opc == 6'b001000) || (opc == 6'b000010) ||
               (BNE_EN && opc == 6'b000101);
    endfunction

    // Expected outputs for one step, straight from the per-state output table.
    function automatic logic [18:0] expect_step(step_t s);
        logic pe, io, mw, iw, rd, mtr, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pe, io, mw, iw, rd, mtr, rw, asa, ill} = '0;
        {asb, aop, psrc} = '0;
        case (s.st)
            0:  begin asb = 2'b01; iw = s.mr; pe = s.mr; end
            1:  begin asb = 2'b11; ill = s.ill; end
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  io = 1'b1;
            4:  begin mtr = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pe = s.bne ? ~s.z : s.z; end
            9:  begin asa = 1'b1; asb = 2'b10; end
            10: rw = 1'b1;
            11: begin psrc = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {pe, io, mw, iw, rd, mtr, rw, asa, asb, aop, psrc, ill, 4'(s.st)};
    endfunction

    function automatic logic [18:0] observed();
        return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, illegal_op, state};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expand one instruction into its expected cycle sequence, including stall cycles.
    task automatic build(input logic [5:0] opc, input int sf, input int sm, input bit z);
        for (int i = 0; i < sf; i++) q.push_back(mk(0, 1'b0, 1'b0, opc, 1'b0, 1'b0));
        q.push_back(mk(0, 1'b1, 1'b0, opc, 1'b0, 1'b0));
        q.push_back(mk(1, 1'b0, 1'b0, opc, !is_legal(opc), 1'b0));
        if (opc == 6'b100011) begin
            q.push_back(mk(2, 1'b0, 1'b0, opc, 1'b0, 1'b0));
            for (int i = 0; i < sm; i++) q.push_back(mk(3, 1'b0, 1'b0, opc, 1'b0, 1'b0));
            q.push_back(mk(3, 1'b1, 1'b0, opc, 1'b0, 1'b0));
            q.push_back(mk(4, 1'b0, 1'b0, opc, 1'b0, 1'b0));
        end else if (opc == 6'b101011) begin
            q.push_back(mk(2, 1'b0, 1'b0, opc, 1'b0, 1'b0));
            for (int i = 0; i < sm; i++) q.push_back(mk(5, 1'b0, 1'b0, opc, 1'b0, 1'b0));
            q.push_back(mk(5, 1'b1, 1'b0, opc, 1'b0, 1'b0));
        end else if (opc == 6'b000000) begin
            q.push_back(mk(6, 1'b0, 1'b0, opc, 1'b0, 1'b0));
            q.push_back(mk(7, 1'b0, 1'b0, opc, 1'b0, 1'b0));
        end else if (opc == 6'b001000) begin
            q.push_back(mk(9, 1'b0, 1'b0, opc, 1'b0, 1'b0));
            q.push_back(mk(10, 1'b0, 1'b0, opc, 1'b0, 1'b0));
        end else if (opc == 6'b000100) begin
            q.push_back(mk(8, 1'b0, z, opc, 1'b0, 1'b0));
        end else if (opc == 6'b000101 && BNE_EN) begin
            q.push_back(mk(8, 1'b0, z, opc, 1'b0, 1'b1));
        end else if (opc == 6'b000010) begin
            q.push_back(mk(11, 1'b0, 1'b0, opc, 1'b0, 1'b0));
        end
    endtask

    // Drive one cycle (don't-care inputs randomised), check at the falling edge, end just past the rising edge.
    task automatic run_cycle(input step_t s, input string tag);
        opcode    = (s.st == 1 || s.st == 2) ? s.opc : 6'($urandom);
        mem_ready = (s.st == 0 || s.st == 3 || s.st == 5) ? s.mr : 1'($urandom);
        zero      = (s.st == 8) ? s.z : 1'($urandom);
        @(negedge clk);
        check($sformatf("%s st%0d", tag, s.st), observed(), expect_step(s));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] opc, input int sf, input int sm, input bit z,
                             input string tag);
        build(opc, sf, sm, z);
        while (q.size() > 0) run_cycle(q.pop_front(), tag);
    endtask

    logic [5:0] legal_ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b001000, 6'b000010, 6'b000101};

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = 6'b000000;
        @(posedge clk);
        #1;
        check("reset_hold", observed(), expect_step(mk(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'b100011, 0, 0, 1'b0, "lw");
        run_instr(6'b000000, 0, 0, 1'b0, "rtype");
        run_instr(6'b101011, 0, 3, 1'b0, "sw_stall");
        run_instr(6'b000100, 0, 0, 1'b1, "beq_taken");
        run_instr(6'b000100, 0, 0, 1'b0, "beq_not");
        run_instr(6'b000010, 0, 0, 1'b0, "jump");
        run_instr(6'b111111, 0, 0, 1'b0, "illegal");
        run_instr(6'b000101, 0, 0, 1'b0, "bne_z0");
        run_instr(6'b000101, 1, 0, 1'b1, "bne_z1");
        run_instr(6'b001000, 2, 0, 1'b0, "addi_fstall");
        run_instr(6'b100011, 1, 2, 1'b0, "lw_stall");

        // Reset arriving mid-EXEC must return to FETCH without a clock edge.
        build(6'b000000, 0, 0, 1'b0);
        run_cycle(q.pop_front(), "rst_mid");
        run_cycle(q.pop_front(), "rst_mid");
        q.delete();
        mem_ready = 1'b1;
        #1;
        check("rst_mid exec", observed(), expect_step(mk(6, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0)));
        reset = 1'b1;
        #1;
        check("rst_mid async", observed(), expect_step(mk(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        check("rst_mid held", observed(), expect_step(mk(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0)));
        reset = 1'b0;
        run_instr(6'b000000, 0, 0, 1'b0, "post_rst");

        for (int n = 0; n < 200; n++) begin
            logic [5:0] opc;
            if ($urandom_range(0, 9) < 8) opc = legal_ops[$urandom_range(0, 6)];
            else opc = 6'($urandom);
            run_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom),
                      $sformatf("rand%0d op%b", n, opc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
